// File: rtl/bpsk_tx_pkg.sv
// ---------------------------------------------------------------------------
// bpsk_tx_pkg
// Shared definitions for the BPSK transmit frame scheduler: the frame
// sequencing states and the default frame-format constants.
// No ports (package).
// ---------------------------------------------------------------------------
package bpsk_tx_pkg;

  // Frame sequencing states. The scheduler stores these as plain 2-bit
  // codes so the encoding stays stable for existing register maps.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SYNC = 2'd2,
    PAY  = 2'd3
  } state_e;

  localparam int         DEF_SYM_CYCLES = 20;     // 200 MHz / 20 = 10 Msym/s
  localparam int         DEF_PRE_LEN    = 16;     // preamble symbols, 1,0,1,0...
  localparam logic [7:0] DEF_SYNC_WORD  = 8'hD3;  // sent MSB first after preamble
  localparam int         DEF_LEN_W      = 8;      // payload byte count width

endpackage

// File: rtl/bpsk_tx_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// bpsk_tx_frame_scheduler_if
// Byte-stream handshake between the payload source and the frame scheduler.
//   s_data   [7:0]  payload byte (source -> scheduler)
//   s_valid         s_data valid (source -> scheduler)
//   s_ready         byte taken when s_valid & s_ready (scheduler -> source)
// Modports: master = byte source, slave = frame scheduler.
// ---------------------------------------------------------------------------
interface bpsk_tx_frame_scheduler_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/bpsk_symbol_timer.sv
// ---------------------------------------------------------------------------
// bpsk_symbol_timer
// Symbol-period counter: counts 0..SYM_CYCLES-1 while enabled and wraps.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           count enable (scheduler busy)
//   clr          force the count back to 0 (frame start)
//   wrap         high in the last cycle of a symbol while enabled
//   last         count is at SYM_CYCLES-1 (independent of en)
// ---------------------------------------------------------------------------
module bpsk_symbol_timer #(
  parameter int SYM_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap,
  output logic last
);

  localparam int            CW       = $clog2(SYM_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(SYM_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= last ? '0 : cnt_reg + CW'(1);
    end
  end

  assign last = (cnt_reg == LAST_CNT);
  assign wrap = en & last;

endmodule

// File: rtl/bpsk_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// bpsk_tx_frame_scheduler
// Serialises preamble, sync word and LEN payload bytes (MSB first) onto
// mod_bit, one bit per SYM_CYCLES-clock symbol, and drives the modulator
// enable / phase clear.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       1-cycle frame request, ignored while busy or len == 0
//   len         payload byte count, sampled on an accepted start
//   s           byte-stream slave (s_data / s_valid / s_ready)
//   mod_en      modulator enable, high for the whole frame
//   mod_bit     current symbol bit, held for SYM_CYCLES clocks
//   mod_clr     carrier phase clear, high in the cycle a start is accepted
//   busy        scheduler not idle
//   done        1-cycle pulse at frame end (normal or starved)
//   underrun    sticky payload-starvation flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module bpsk_tx_frame_scheduler
  import bpsk_tx_pkg::*;
#(
  parameter int         SYM_CYCLES = DEF_SYM_CYCLES,
  parameter int         PRE_LEN    = DEF_PRE_LEN,
  parameter logic [7:0] SYNC_WORD  = DEF_SYNC_WORD,
  parameter int         LEN_W      = DEF_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  bpsk_tx_frame_scheduler_if.slave  s,
  output logic                      mod_en,
  output logic                      mod_bit,
  output logic                      mod_clr,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_PRE  = PRE;
  localparam logic [1:0] ST_SYNC = SYNC;
  localparam logic [1:0] ST_PAY  = PAY;

  localparam int            PW       = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);

  logic [1:0]       state_reg;
  logic [PW-1:0]    pre_idx_reg;
  logic [2:0]       bit_idx_reg;     // bits already sent of the current byte
  logic [7:0]       shreg_reg;       // remaining bits of sync word / byte
  logic [LEN_W-1:0] bytes_left_reg;  // bytes still to send, incl. current one
  logic             mod_en_reg;
  logic             mod_bit_reg;
  logic             done_reg;
  logic             underrun_reg;

  logic start_ok;
  logic sym_wrap;
  logic sym_last;
  logic fetch;

  assign start_ok = start & (state_reg == ST_IDLE) & (len != '0);

  bpsk_symbol_timer #(
    .SYM_CYCLES (SYM_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_reg != ST_IDLE),
    .clr   (start_ok),
    .wrap  (sym_wrap),
    .last  (sym_last)
  );

  // The next byte is requested only in the final cycle of the last bit of
  // the sync word or of a payload byte that is not the frame's last byte.
  assign fetch = sym_last & (bit_idx_reg == 3'd7) &
                 ((state_reg == ST_SYNC) |
                  ((state_reg == ST_PAY) & (bytes_left_reg != LEN_W'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pre_idx_reg    <= '0;
      bit_idx_reg    <= '0;
      shreg_reg      <= '0;
      bytes_left_reg <= '0;
      mod_en_reg     <= 1'b0;
      mod_bit_reg    <= 1'b0;
      done_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            state_reg      <= ST_PRE;
            pre_idx_reg    <= '0;
            bytes_left_reg <= len;
            underrun_reg   <= 1'b0;
            mod_en_reg     <= 1'b1;
            mod_bit_reg    <= 1'b1;   // preamble starts with 1
          end
        end
        ST_PRE: begin
          if (sym_wrap) begin
            if (pre_idx_reg == PRE_LAST) begin
              state_reg   <= ST_SYNC;
              bit_idx_reg <= '0;
              mod_bit_reg <= SYNC_WORD[7];
              shreg_reg   <= {SYNC_WORD[6:0], 1'b0};
            end else begin
              // Symbol k carries ~k[0]; for k = idx+1 that equals idx[0].
              pre_idx_reg <= pre_idx_reg + PW'(1);
              mod_bit_reg <= pre_idx_reg[0];
            end
          end
        end
        ST_SYNC, ST_PAY: begin
          if (sym_wrap) begin
            if (bit_idx_reg != 3'd7) begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              mod_bit_reg <= shreg_reg[7];
              shreg_reg   <= {shreg_reg[6:0], 1'b0};
            end else if (fetch && s.s_valid) begin
              state_reg   <= ST_PAY;
              bit_idx_reg <= '0;
              mod_bit_reg <= s.s_data[7];
              shreg_reg   <= {s.s_data[6:0], 1'b0};
              // The byte taken at the end of sync is byte 1; only later
              // fetches retire a byte from the count.
              if (state_reg == ST_PAY) begin
                bytes_left_reg <= bytes_left_reg - LEN_W'(1);
              end
            end else begin
              // Either the last byte finished or the source starved us;
              // a starved frame ends here without a partial byte.
              state_reg   <= ST_IDLE;
              mod_en_reg  <= 1'b0;
              mod_bit_reg <= 1'b0;
              done_reg    <= 1'b1;
              if (fetch) begin
                underrun_reg <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s.s_ready = fetch;
  assign mod_clr   = start_ok;
  assign mod_en    = mod_en_reg;
  assign mod_bit   = mod_bit_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign underrun  = underrun_reg;

endmodule

// File: tb/tb_bpsk_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bpsk_tx_frame_scheduler
// Randomised frames against a symbol-level reference model. Stimulus pushes
// the expected per-clock symbol stream of each frame into a queue; a
// monitor on the falling edge pops it and compares every DUT output.
// ---------------------------------------------------------------------------
module tb_bpsk_tx_frame_scheduler;

  localparam int SC = 20;     // clocks per symbol
  localparam int P  = 16;     // preamble symbols

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       mod_en, mod_bit, mod_clr, busy, done, underrun;

  always #5 clk = ~clk;

  bpsk_tx_frame_scheduler_if sif ();

  bpsk_tx_frame_scheduler #(
    .SYM_CYCLES (SC),
    .PRE_LEN    (P),
    .SYNC_WORD  (8'hD3),
    .LEN_W      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .s        (sif.slave),
    .mod_en   (mod_en),
    .mod_bit  (mod_bit),
    .mod_clr  (mod_clr),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_prints = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      if (n_prints < 40) begin
        $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
      n_prints++;
    end
  endtask

  // ---------------- scoreboard state ----------------
  bit   exp_q[$];          // expected mod_bit for each clock of the frame
  int   frame_total = 0;
  int   frame_len   = 0;
  bit   frame_under = 1'b0;
  bit   exp_underrun = 1'b0;
  bit   prev_active = 1'b0;
  int   hs_count  = 0;
  int   hs_expect = 0;

  // ---------------- byte source ----------------
  logic [7:0] src_q[$];
  int         src_idx   = 0;
  int         src_allow = 0;  // bytes offered before s_valid is withdrawn
  bit         src_hs;

  task automatic src_update();
    sif.s_valid = (src_idx < src_allow) && (src_idx < src_q.size());
    sif.s_data  = sif.s_valid ? src_q[src_idx] : 8'h00;
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    forever begin
      @(negedge clk);
      src_hs = rst_n && sif.s_valid && sif.s_ready;
      @(posedge clk);
      #1;
      if (src_hs) begin
        hs_count++;
        src_idx++;
        src_update();
      end
    end
  end

  // ---------------- monitor ----------------
  bit m_active, m_bit, m_ready, m_done;
  int m_c, m_rel;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_active = 1'b0;
      end else begin
        m_active = (exp_q.size() > 0);
        m_bit    = m_active ? exp_q[0] : 1'b0;
        m_c      = frame_total - exp_q.size();
        m_rel    = m_c + 1 - (P + 8) * SC;
        m_ready  = m_active && (m_rel >= 0) && ((m_rel % (8 * SC)) == 0) &&
                   ((m_rel / (8 * SC)) < frame_len);
        m_done   = prev_active && !m_active;
        if (m_done) exp_underrun = frame_under;
        check("mod_en",   mod_en,      m_active);
        check("mod_bit",  mod_bit,     m_bit);
        check("busy",     busy,        m_active);
        check("s_ready",  sif.s_ready, m_ready);
        check("done",     done,        m_done);
        check("underrun", underrun,    exp_underrun);
        if (m_done) begin
          check("handshakes", hs_count, hs_expect);
          $display("frame end: len=%0d handshakes=%0d underrun=%0b", frame_len, hs_count, underrun);
        end
        if (m_active) void'(exp_q.pop_front());
        prev_active = m_active;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Caller loads src_q. d = bytes the source will supply; d < L starves.
  // ign_at / abort_at: frame clock at which to pulse an ignored start or
  // assert reset (0 = never).
  task automatic run_frame(input int L, input int d, input int ign_at, input int abort_at);
    logic [7:0] sw;
    logic [7:0] by;
    int         nb;
    int         budget;
    bit         finished;
    sw = 8'hD3;
    src_idx = 0;
    src_allow = d;
    hs_count = 0;
    src_update();
    @(posedge clk);
    #1;
    start = 1'b1;
    len = L[7:0];
    @(negedge clk);
    check("mod_clr_accept", mod_clr, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    len = 8'($urandom);
    // Reference: preamble, sync word, then every byte the source delivers.
    nb = (d < L) ? d : L;
    exp_q.delete();
    for (int k = 0; k < P; k++)
      for (int c = 0; c < SC; c++) exp_q.push_back((k % 2) == 0);
    for (int i = 7; i >= 0; i--)
      for (int c = 0; c < SC; c++) exp_q.push_back(sw[i]);
    for (int j = 0; j < nb; j++) begin
      by = src_q[j];
      for (int i = 7; i >= 0; i--)
        for (int c = 0; c < SC; c++) exp_q.push_back(by[i]);
    end
    frame_total  = exp_q.size();
    frame_len    = L;
    frame_under  = (d < L);
    hs_expect    = nb;
    exp_underrun = 1'b0;
    $display("frame start: len=%0d bytes_supplied=%0d clocks=%0d ign_at=%0d abort_at=%0d",
             L, nb, frame_total, ign_at, abort_at);
    budget   = frame_total + 20;
    finished = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (start) check("mod_clr_ignored", mod_clr, 1'b0);
      #1;
      if (n > 1 && exp_q.size() == 0 && !prev_active) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      start = (n == ign_at);
      if (start) len = 8'($urandom_range(0, 255));
      if (n == abort_at) begin
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_underrun = 1'b0;
        src_allow = 0;
        src_update();
        #1;
        check("async_reset_outputs",
              {25'd0, mod_en, mod_bit, mod_clr, busy, done, underrun, sif.s_ready}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        $display("frame aborted by reset at frame clock %0d", n);
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) begin
      n_checks++;
      $display("FAIL frame_timeout: busy=%0b, required idle within %0d clocks", busy, budget);
    end
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
  endtask

  int rl, rd, rnb, rign;

  initial begin
    rst_n = 1'b0;
    src_allow = 0;
    src_update();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {25'd0, mod_en, mod_bit, mod_clr, busy, done, underrun, sif.s_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single byte A5
    src_q.delete(); src_q.push_back(8'hA5);
    run_frame(1, 1, 0, 0);

    // three bytes 00, FF, 3C
    src_q.delete(); src_q.push_back(8'h00); src_q.push_back(8'hFF); src_q.push_back(8'h3C);
    run_frame(3, 3, 0, 0);

    // starvation at the second fetch, then a clean frame clears underrun
    fill_random(2);
    run_frame(2, 1, 0, 0);
    fill_random(1);
    run_frame(1, 1, 0, 0);

    // starvation at the very first fetch (end of sync)
    fill_random(2);
    run_frame(2, 0, 0, 0);

    // len = 0 in idle is ignored
    @(posedge clk); #1; start = 1'b1; len = 8'd0;
    @(negedge clk);
    check("mod_clr_len0", mod_clr, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_len0", busy, 1'b0);

    // start while busy is ignored
    fill_random(2);
    run_frame(2, 2, 100, 0);
    fill_random(1);
    run_frame(1, 1, (P + 8) * SC + 5, 0);

    // reset in the middle of the second payload byte, then a normal frame
    fill_random(3);
    run_frame(3, 3, 0, (P + 8 + 8) * SC + 30);
    fill_random(1);
    run_frame(1, 1, 0, 0);

    // randomised frames
    for (int f = 0; f < 6; f++) begin
      rl  = $urandom_range(1, 4);
      rd  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rl - 1) : rl;
      rnb = (rd < rl) ? rd : rl;
      rign = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (P + 8 + 8 * rnb) * SC - 3) : 0;
      fill_random(rl);
      run_frame(rl, rd, rign, 0);
    end

    // maximum length frame
    fill_random(255);
    run_frame(255, 255, 0, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
